// File: rtl/de0_pll_rstctl_if.sv
// Lock/reset handshake between the DE0 PLL reset controller and the PLL/system side.
// master: the controller; slave: the PLL lock source and the reset consumers.
interface de0_pll_rstctl_if;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       err;
    logic [7:0] relock_count;

    modport master (
        input  locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output err,
        output relock_count
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  err,
        input  relock_count
    );
endinterface

// File: rtl/de0_pll_rstctl.sv
// DE0 PLL reset/lock controller: resets the PLL, waits for a stable lock, then releases sys_rst.
// Optional macro DE0_PLL_RSTCTL_GLITCH_FILTER_EN ignores lock drops of up to 3 cycles while running.
module de0_pll_rstctl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 20
) (
    input  logic               clkin,
    input  logic               rst,
    de0_pll_rstctl_if.master   bus
);

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {PLLRST, WAIT_LOCK, STABLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             pll_rst_q;
    logic             sys_rst_q;
    logic             ready_q;
    logic             err_q;
    logic [7:0]       relock_q;
    logic             locked_s;
    logic             lock_loss;

    assign locked_s = sync2_q;

    // locked comes from the PLL's own lock detector, unrelated to clkin timing
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.locked;
            sync2_q <= sync1_q;
        end
    end

`ifdef DE0_PLL_RSTCTL_GLITCH_FILTER_EN
    logic [1:0] filt_q;

    assign lock_loss = !locked_s && (filt_q == 2'd3);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            filt_q <= 2'd0;
        end else if (state_q != RUN || locked_s) begin
            filt_q <= 2'd0;
        end else if (filt_q != 2'd3) begin
            filt_q <= filt_q + 2'd1;
        end
    end
`else
    assign lock_loss = !locked_s;
`endif

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            relock_q  <= 8'd0;
        end else begin
            case (state_q)
                PLLRST: begin
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    if (cnt_q == PLL_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // lock takes priority over a timeout landing in the same cycle
                    if (locked_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= PLLRST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (lock_loss) begin
                        state_q   <= PLLRST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        sys_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        if (relock_q != 8'hFF) begin
                            relock_q <= relock_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= PLLRST;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.err          = err_q;
    assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_de0_pll_rstctl.sv
// Scoreboard bench for de0_pll_rstctl with short cycle parameters.
// Define DE0_PLL_RSTCTL_GLITCH_FILTER_EN for both DUT and bench to exercise the lock-loss filter.
module tb_de0_pll_rstctl;

    localparam int P = 4;
    localparam int T = 100;
    localparam int S = 16;
`ifdef DE0_PLL_RSTCTL_GLITCH_FILTER_EN
    localparam int LOSS_LEN   = 4;
    localparam int LOSS_EDGES = 6;
`else
    localparam int LOSS_LEN   = 1;
    localparam int LOSS_EDGES = 3;
`endif

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    logic clkin;
    logic rst;
    int   totalChecks;
    int   badChecks;
    exp_t sb[$];

    de0_pll_rstctl_if bus();

    de0_pll_rstctl #(
        .PLL_RST_CYCLES(P),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S),
        .CNT_W         (20)
    ) dut (
        .clkin(clkin),
        .rst  (rst),
        .bus  (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Hard stop in case a bounded wait is somehow bypassed
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation ran past 500 us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        totalChecks++;
        if (observed !== 32'(expected)) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, $signed(observed), expected);
        end
    endtask

    task automatic expectVal(input string tag, input int value);
        sb.push_back('{tag, value});
    endtask

    task automatic popCheck(input logic [31:0] observed);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sbDepth", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic lockedVal);
        rst        = rstVal;
        bus.locked = lockedVal;
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic sigSel(input int sel);
        case (sel)
            0:       return bus.pll_rst;
            1:       return bus.sys_rst;
            2:       return bus.ready;
            default: return bus.err;
        endcase
    endfunction

    // Edges until the selected output reaches val; -1 when the budget runs out
    task automatic waitSig(input int sel, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sigSel(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Low pulse of lowEdges sampled edges on locked; returns edges until sys_rst rises or -1
    task automatic dropLock(input int lowEdges, input int budget, output int n);
        n = -1;
        bus.locked = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (i == lowEdges) bus.locked = 1'b1;
            if (bus.sys_rst === 1'b1) begin
                n = i;
                break;
            end
        end
        bus.locked = 1'b1;
    endtask

    task automatic checkResetValues(input string pfx);
        expectVal({pfx, "PllRst"}, 1);
        expectVal({pfx, "SysRst"}, 1);
        expectVal({pfx, "Ready"}, 0);
        expectVal({pfx, "Err"}, 0);
        expectVal({pfx, "Relock"}, 0);
        popCheck(32'(bus.pll_rst));
        popCheck(32'(bus.sys_rst));
        popCheck(32'(bus.ready));
        popCheck(32'(bus.err));
        popCheck(32'(bus.relock_count));
    endtask

    initial begin
        int n;
        totalChecks = 0;
        badChecks   = 0;

        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        checkResetValues("rst");

        // Normal bring-up with lock arriving 10 cycles into WAIT_LOCK
        applyStimulus(1'b0, 1'b0);
        expectVal("s1PllRstLen", P);
        waitSig(0, 1'b0, 50, n);
        popCheck(32'(n));
        repeat (10) tick();
        bus.locked = 1'b1;
        expectVal("s1SysRstEdge", S + 3);
        waitSig(1, 1'b0, 100, n);
        popCheck(32'(n));
        expectVal("s1Ready", 1);
        expectVal("s1Err", 0);
        expectVal("s1Relock", 0);
        expectVal("s1PllRst", 0);
        popCheck(32'(bus.ready));
        popCheck(32'(bus.err));
        popCheck(32'(bus.relock_count));
        popCheck(32'(bus.pll_rst));

        // No lock: periodic timeouts with sticky err, cleared only on RUN
        applyStimulus(1'b1, 1'b0);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0);
        expectVal("s2PllRstLen", P);
        waitSig(0, 1'b0, 50, n);
        popCheck(32'(n));
        expectVal("s2TimeoutEdge", T);
        waitSig(3, 1'b1, 300, n);
        popCheck(32'(n));
        expectVal("s2PllRstOnTo", 1);
        popCheck(32'(bus.pll_rst));
        expectVal("s2RetryPllLen", P);
        waitSig(0, 1'b0, 50, n);
        popCheck(32'(n));
        expectVal("s2ErrSticky", 1);
        popCheck(32'(bus.err));
        expectVal("s2Timeout2", T);
        waitSig(0, 1'b1, 300, n);
        popCheck(32'(n));
        expectVal("s2RetryPllLen2", P);
        waitSig(0, 1'b0, 50, n);
        popCheck(32'(n));
        bus.locked = 1'b1;
        expectVal("s2SysRstEdge", S + 3);
        waitSig(1, 1'b0, 100, n);
        popCheck(32'(n));
        expectVal("s2ErrCleared", 0);
        expectVal("s2Ready", 1);
        popCheck(32'(bus.err));
        popCheck(32'(bus.ready));

        // Lock losses in RUN, repeated until relock_count saturates
        expectVal("s3LossEdge", LOSS_EDGES);
        dropLock(LOSS_LEN, 20, n);
        popCheck(32'(n));
        expectVal("s3PllRst", 1);
        expectVal("s3Ready", 0);
        expectVal("s3Relock1", 1);
        popCheck(32'(bus.pll_rst));
        popCheck(32'(bus.ready));
        popCheck(32'(bus.relock_count));
        expectVal("s3RelockTime", P + 1 + S);
        waitSig(2, 1'b1, 100, n);
        popCheck(32'(n));
        for (int i = 2; i <= 300; i++) begin
            dropLock(LOSS_LEN, 20, n);
            waitSig(2, 1'b1, 100, n);
            if (i == 255 || i == 256 || i == 300) begin
                expectVal($sformatf("s3Relock%0d", i), (i > 255) ? 255 : i);
                popCheck(32'(bus.relock_count));
            end
        end

        // Lock drop during STABLE falls back to WAIT_LOCK without counting
        applyStimulus(1'b1, 1'b1);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b1);
        repeat (13) tick();
        bus.locked = 1'b0;
        repeat (4) tick();
        expectVal("s4SysRstHeld", 1);
        expectVal("s4PllRstLow", 0);
        popCheck(32'(bus.sys_rst));
        popCheck(32'(bus.pll_rst));
        bus.locked = 1'b1;
        expectVal("s4SysRstEdge", S + 3);
        waitSig(1, 1'b0, 100, n);
        popCheck(32'(n));
        expectVal("s4Relock", 0);
        popCheck(32'(bus.relock_count));

        // Asynchronous reset between edges while running
        dropLock(LOSS_LEN, 20, n);
        waitSig(2, 1'b1, 100, n);
        expectVal("s5RelockBefore", 1);
        popCheck(32'(bus.relock_count));
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        checkResetValues("s5Async");

`ifdef DE0_PLL_RSTCTL_GLITCH_FILTER_EN
        // Filter: 3-cycle pulse ignored, 4-cycle pulse is a loss
        @(posedge clkin);
        #1;
        applyStimulus(1'b0, 1'b1);
        expectVal("s6RunTime", P + 1 + S);
        waitSig(2, 1'b1, 100, n);
        popCheck(32'(n));
        expectVal("s6Pulse3", -1);
        dropLock(3, 10, n);
        popCheck(32'(n));
        expectVal("s6Pulse3Relock", 0);
        expectVal("s6Pulse3Ready", 1);
        popCheck(32'(bus.relock_count));
        popCheck(32'(bus.ready));
        expectVal("s6Pulse4Edge", 6);
        dropLock(4, 20, n);
        popCheck(32'(n));
        expectVal("s6Pulse4Relock", 1);
        popCheck(32'(bus.relock_count));
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
